// File: rtl/ctrl_pipe_regs.sv
// rtl/ctrl_pipe_regs.sv - ID->EX->MEM->WB control pipeline registers with hazard, flush and halt-drain control
module ctrl_pipe_regs #(
   parameter int REG_AW = 5,
   parameter int CTRL_W = 11
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic              id_halt,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              ex_redirect,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic [REG_AW-1:0] ex_rd,
   output logic [3:0]        mem_ctrl,
   output logic [REG_AW-1:0] mem_rd,
   output logic              wb_regwrite,
   output logic              wb_memtoreg,
   output logic [REG_AW-1:0] wb_rd,
   output logic              stall,
   output logic              flush_ifid,
   output logic              halted
);

   // Bundle bit positions
   localparam int B_MEMTOREG = 1;
   localparam int B_REGWRITE = 2;
   localparam int B_MEMREAD  = 3;
   localparam int B_MEMWRITE = 4;
   localparam int B_BRANCH   = 8;
   localparam int B_JUMP     = 9;

   logic ex_halt;
   logic mem_halt;
   logic wb_halt;

   logic redir;
   logic lu;
   logic hp;

   // Hazard and redirect detection; halted keeps fetch frozen after the drain completes
   always_comb begin
      redir = ex_redirect & (ex_ctrl[B_BRANCH] | ex_ctrl[B_JUMP]);
      lu    = ex_ctrl[B_MEMREAD] & (ex_rd != '0) & ((ex_rd == id_rs1) | (ex_rd == id_rs2));
      hp    = ex_halt | mem_halt | wb_halt | halted;
      flush_ifid = redir;
      stall      = ~redir & (hp | lu);
   end

   // ID->EX load: bubble on redirect, pending halt or load-use, otherwise take the decoder bundle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_ctrl <= '0;
         ex_rd   <= '0;
         ex_halt <= 1'b0;
      end else if (redir || hp || lu) begin
         ex_ctrl <= '0;
         ex_rd   <= '0;
         ex_halt <= 1'b0;
      end else begin
         ex_ctrl <= id_ctrl;
         ex_rd   <= id_rd;
         ex_halt <= id_halt;
      end
   end

   // EX->MEM->WB always advance; only the fields consumed downstream are carried
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_ctrl    <= '0;
         mem_rd      <= '0;
         mem_halt    <= 1'b0;
         wb_regwrite <= 1'b0;
         wb_memtoreg <= 1'b0;
         wb_rd       <= '0;
         wb_halt     <= 1'b0;
      end else begin
         mem_ctrl    <= {ex_ctrl[B_MEMTOREG], ex_ctrl[B_REGWRITE],
                         ex_ctrl[B_MEMREAD], ex_ctrl[B_MEMWRITE]};
         mem_rd      <= ex_rd;
         mem_halt    <= ex_halt;
         wb_regwrite <= mem_ctrl[2];
         wb_memtoreg <= mem_ctrl[3];
         wb_rd       <= mem_rd;
         wb_halt     <= mem_halt;
      end
   end

   // Sticky halted flag, set when the halt retires from WB
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         halted <= 1'b0;
      end else if (wb_halt) begin
         halted <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ctrl_pipe_regs.sv
// tb/tb_ctrl_pipe_regs.sv - directed self-checking bench for ctrl_pipe_regs
module tb_ctrl_pipe_regs;

   logic        clk;
   logic        rst_n;
   logic [10:0] id_ctrl;
   logic        id_halt;
   logic [4:0]  id_rs1;
   logic [4:0]  id_rs2;
   logic [4:0]  id_rd;
   logic        ex_redirect;
   logic [10:0] ex_ctrl;
   logic [4:0]  ex_rd;
   logic [3:0]  mem_ctrl;
   logic [4:0]  mem_rd;
   logic        wb_regwrite;
   logic        wb_memtoreg;
   logic [4:0]  wb_rd;
   logic        stall;
   logic        flush_ifid;
   logic        halted;

   int errors = 0;
   int checks = 0;

   ctrl_pipe_regs #(.REG_AW(5), .CTRL_W(11)) dut (
      .clk(clk), .rst_n(rst_n),
      .id_ctrl(id_ctrl), .id_halt(id_halt),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .ex_redirect(ex_redirect),
      .ex_ctrl(ex_ctrl), .ex_rd(ex_rd),
      .mem_ctrl(mem_ctrl), .mem_rd(mem_rd),
      .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg), .wb_rd(wb_rd),
      .stall(stall), .flush_ifid(flush_ifid), .halted(halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      id_ctrl = '0; id_halt = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rd = '0; ex_redirect = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
   endtask

   initial begin
      idle_inputs();
      rst_n = 1'b0;
      #12;
      check("rst_ex_ctrl", ex_ctrl, 0);
      check("rst_mem_ctrl", mem_ctrl, 0);
      check("rst_wb_regwrite", wb_regwrite, 0);
      check("rst_halted", halted, 0);
      check("rst_stall", stall, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;

      // Flow
      id_ctrl = 11'h004; id_rd = 5'd5;
      #1;
      check("flow_stall0", stall, 0);
      tick();
      check("flow_ex_ctrl", ex_ctrl, 11'h004);
      check("flow_ex_rd", ex_rd, 5);
      idle_inputs();
      #1;
      check("flow_stall1", stall, 0);
      tick();
      check("flow_mem_ctrl", mem_ctrl, 4'b0100);
      check("flow_mem_rd", mem_rd, 5);
      check("flow_stall2", stall, 0);
      tick();
      check("flow_wb_regwrite", wb_regwrite, 1);
      check("flow_wb_memtoreg", wb_memtoreg, 0);
      check("flow_wb_rd", wb_rd, 5);
      check("flow_stall3", stall, 0);

      // Load-use on rs2
      id_ctrl = 11'h00F; id_rd = 5'd3;
      tick();
      check("lu_ex_ld", ex_ctrl, 11'h00F);
      id_ctrl = 11'h004; id_rs2 = 5'd3; id_rd = 5'd7;
      #1;
      check("lu_stall", stall, 1);
      check("lu_noflush", flush_ifid, 0);
      tick();
      check("lu_bubble_ctrl", ex_ctrl, 0);
      check("lu_bubble_rd", ex_rd, 0);
      check("lu_stall_once", stall, 0);
      tick();
      check("lu_resume_ctrl", ex_ctrl, 11'h004);
      check("lu_resume_rd", ex_rd, 7);
      check("lu_mem_load", mem_ctrl, 4'b0000);

      // Load to x0 never stalls
      idle_inputs();
      id_ctrl = 11'h00F; id_rd = 5'd0;
      tick();
      id_ctrl = 11'h004; id_rs2 = 5'd0; id_rd = 5'd8;
      #1;
      check("lu_x0_stall", stall, 0);
      tick();
      check("lu_x0_ex", ex_ctrl, 11'h004);
      idle_inputs();

      // Branch flush cancels a halt in ID
      id_ctrl = 11'h100;
      tick();
      check("br_ex_ctrl", ex_ctrl, 11'h100);
      ex_redirect = 1'b1; id_halt = 1'b1; id_ctrl = 11'h004; id_rd = 5'd9;
      #1;
      check("br_flush", flush_ifid, 1);
      check("br_stall", stall, 0);
      tick();
      check("br_bubble", ex_ctrl, 0);
      id_halt = 1'b0; id_ctrl = '0; id_rd = '0;
      #1;
      check("br_redir_bubble_noflush", flush_ifid, 0);
      check("br_redir_bubble_nostall", stall, 0);
      ex_redirect = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      check("br_no_halted", halted, 0);
      check("br_no_stall", stall, 0);

      // Redirect wins over a simultaneous load-use
      id_ctrl = 11'h108; id_rd = 5'd3;
      tick();
      id_ctrl = 11'h004; id_rs1 = 5'd3; ex_redirect = 1'b1;
      #1;
      check("fvs_stall", stall, 0);
      check("fvs_flush", flush_ifid, 1);
      tick();
      check("fvs_bubble", ex_ctrl, 0);
      idle_inputs();

      // Asynchronous reset mid-stream
      id_ctrl = 11'h006; id_rd = 5'd9;
      tick(); tick(); tick();
      check("pre_rst_wb", wb_regwrite, 1);
      rst_n = 1'b0;
      #1;
      check("arst_ex_ctrl", ex_ctrl, 0);
      check("arst_ex_rd", ex_rd, 0);
      check("arst_mem_ctrl", mem_ctrl, 0);
      check("arst_mem_rd", mem_rd, 0);
      check("arst_wb_regwrite", wb_regwrite, 0);
      check("arst_wb_rd", wb_rd, 0);
      check("arst_halted", halted, 0);
      idle_inputs();
      @(negedge clk);
      rst_n = 1'b1;
      #1;

      // Halt drain
      id_halt = 1'b1; id_ctrl = 11'h004; id_rd = 5'd4;
      #1;
      check("halt_accept_stall", stall, 0);
      tick();
      idle_inputs();
      id_ctrl = 11'h004; id_rd = 5'd6;
      #1;
      check("halt_stall_c1", stall, 1);
      check("halt_halted_c1", halted, 0);
      tick();
      check("halt_bubble1", ex_ctrl, 0);
      check("halt_stall_c2", stall, 1);
      check("halt_halted_c2", halted, 0);
      tick();
      check("halt_bubble2", ex_ctrl, 0);
      check("halt_halted_c3", halted, 0);
      tick();
      check("halt_bubble3", ex_ctrl, 0);
      check("halt_halted_c4", halted, 1);
      check("halt_stall_c4", stall, 1);
      for (int i = 0; i < 20; i++) begin
         tick();
         check("halt_sticky", halted, 1);
         check("halt_frozen", stall, 1);
      end
      do_reset();
      check("halt_rst_halted", halted, 0);
      idle_inputs();
      #1;
      check("halt_rst_stall", stall, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
